// File: rtl/fsqrt_sched.sv
// Two-requester front end for a shared, fixed-latency fsqrt pipeline.
// Credit-gated round-robin issue, a result tag pipeline, and one result FIFO per requester.
module fsqrt_sched #(
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  input  logic        rsp1_ready,
  output logic [31:0] fu_s,
  input  logic [31:0] fu_d,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [1:0][31:0] rsp_data;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [1:0]       acc;
  logic [1:0]       cnt_nz;

  logic             ptr_reg;
  logic [31:0]      fu_s_reg;
  logic             busy_reg;
  // Stage 0 lines up with fu_s, so stage LAT lines up with the matching fu_d.
  logic [LAT:0]     vld_reg;
  logic [LAT:0]     tag_reg;

  assign req_valid  = {req1_valid, req0_valid};
  assign rsp_ready  = {rsp1_ready, rsp0_ready};
  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_data  = rsp_data[0];
  assign rsp1_data  = rsp_data[1];
  assign fu_s       = fu_s_reg;
  assign busy       = busy_reg;

  // ptr_reg holds the last granted requester; on a tie the other one wins.
  assign grant[0] = elig[0] && (!elig[1] || ptr_reg);
  assign grant[1] = elig[1] && (!elig[0] || !ptr_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic [AW:0]   wr_ptr_reg;
      logic [AW:0]   rd_ptr_reg;
      logic [31:0]   mem [DEPTH];
      logic          has_credit;
      logic          full;
      logic          empty;
      logic          wr_en;
      logic          rd_en;

      assign has_credit    = cnt_reg < CW'(DEPTH);
      assign elig[gi]      = req_valid[gi] && has_credit;
      assign req_ready[gi] = rstn && has_credit && !grant[1 - gi];
      assign acc[gi]       = req_valid[gi] && req_ready[gi];

      assign empty = (wr_ptr_reg == rd_ptr_reg);
      assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      assign wr_en = vld_reg[LAT] && (tag_reg[LAT] == 1'(gi));

      assign rsp_valid[gi] = rstn && !empty;
      assign rd_en         = rsp_valid[gi] && rsp_ready[gi];
      assign rsp_data[gi]  = mem[rd_ptr_reg[AW-1:0]];
      assign cnt_nz[gi]    = (cnt_next != '0);

      always_comb begin
        cnt_next = cnt_reg;
        if (acc[gi] && !rd_en) begin
          cnt_next = cnt_reg + CW'(1);
        end else if (!acc[gi] && rd_en) begin
          cnt_next = cnt_reg - CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (!rstn) begin
          cnt_reg    <= '0;
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
          if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
          end
          if (rd_en) begin
            rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
          end
        end
      end

      // Storage has no reset so it can map onto plain RAM; pointers gate visibility.
      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem[wr_ptr_reg[AW-1:0]] <= fu_d;
        end
      end

      a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(wr_en && full && !rd_en));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_reg  <= 1'b1;
      fu_s_reg <= 32'h0;
      busy_reg <= 1'b0;
      vld_reg  <= '0;
      tag_reg  <= '0;
    end else begin
      if (|acc) begin
        ptr_reg <= acc[1];
      end
      fu_s_reg <= acc[0] ? req0_data : (acc[1] ? req1_data : 32'h0);
      vld_reg  <= {vld_reg[LAT-1:0], |acc};
      tag_reg  <= {tag_reg[LAT-1:0], acc[1]};
      busy_reg <= |cnt_nz;
    end
  end

endmodule
